// File: rtl/counter_stim_driver_pkg.sv
// Shared types and default sizing for the counter stimulus driver.
package counter_stim_driver_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_HALF_PERIOD = 4;
    localparam int DEF_SETTLE      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_SETTLE,
        ST_CHECK
    } state_t;

endpackage

// File: rtl/counter_stim_driver_phase_timer.sv
// Loadable down-counter: expire is high in the last cycle of a phase of 'len' cycles.
module counter_stim_driver_phase_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [TW-1:0] len,
    output logic          expire
);

    logic [TW-1:0] cnt;
    logic          active;

    // start wins over expiry so phases chain back-to-back without a gap cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cnt    <= len - TW'(1);
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0)
                active <= 1'b0;
            else
                cnt <= cnt - TW'(1);
        end
    end

    assign expire = active && (cnt == '0);

endmodule

// File: rtl/counter_stim_driver.sv
// Command-driven sequencer: loads the counter, clocks it 'steps' times, reads it back
// and flags a mismatch against the arithmetically expected value.
module counter_stim_driver
    import counter_stim_driver_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int SETTLE      = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_load_val,
    input  logic [WIDTH-1:0] cmd_steps,
    input  logic             cmd_up,
    output logic             cnt_enable,
    output logic             cnt_clk,
    output logic             cnt_load,
    output logic             cnt_up_down,
    output logic [WIDTH-1:0] cnt_data,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mismatch
);

    localparam int TMAX = (HALF_PERIOD > SETTLE) ? HALF_PERIOD : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HP_LEN  = TW'(HALF_PERIOD);
    localparam logic [TW-1:0] SET_LEN = TW'(SETTLE);

    function automatic logic [WIDTH-1:0] wrap_expected(input logic [WIDTH-1:0] base,
                                                       input logic [WIDTH-1:0] steps,
                                                       input logic up);
        return up ? (base + steps) : (base - steps);
    endfunction

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] expected_q;
    logic             accept;
    logic             to_settle;
    logic             tmr_start;
    logic             tmr_expire;
    logic [TW-1:0]    tmr_len;

    assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign to_settle = (rem == '0) && ((state == ST_LOAD_LO) || (state == ST_STEP_LO));
    assign tmr_len   = to_settle ? SET_LEN : HP_LEN;
    assign tmr_start = accept ||
                       (tmr_expire && (state inside {ST_LOAD_HI, ST_LOAD_LO, ST_STEP_HI, ST_STEP_LO}));

    counter_stim_driver_phase_timer #(.TW(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (tmr_start),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    // Reference value is pure data: captured on accept, never needs a reset value
    always_ff @(posedge clk) begin
        if (accept)
            expected_q <= wrap_expected(cmd_load_val, cmd_steps, cmd_up);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt_enable  <= 1'b0;
            cnt_clk     <= 1'b0;
            cnt_load    <= 1'b0;
            cnt_up_down <= 1'b0;
            cnt_data    <= '0;
            result      <= '0;
            mismatch    <= 1'b0;
            rem         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    state       <= ST_LOAD_HI;
                    cmd_ready   <= 1'b0;
                    busy        <= 1'b1;
                    cnt_enable  <= 1'b1;
                    cnt_clk     <= 1'b1;
                    cnt_load    <= 1'b1;
                    cnt_up_down <= cmd_up;
                    cnt_data    <= cmd_load_val;
                    rem         <= cmd_steps;
                end
                ST_LOAD_HI: if (tmr_expire) begin
                    state   <= ST_LOAD_LO;
                    cnt_clk <= 1'b0;
                end
                ST_LOAD_LO: if (tmr_expire) begin
                    cnt_load <= 1'b0;
                    if (rem != '0) begin
                        state   <= ST_STEP_HI;
                        cnt_clk <= 1'b1;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                // rem counts pulses still owed after the current one
                ST_STEP_HI: if (tmr_expire) begin
                    state   <= ST_STEP_LO;
                    cnt_clk <= 1'b0;
                    rem     <= rem - WIDTH'(1);
                end
                ST_STEP_LO: if (tmr_expire) begin
                    if (rem != '0) begin
                        state   <= ST_STEP_HI;
                        cnt_clk <= 1'b1;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                // result is captured on entry so it is valid alongside done in CHECK
                ST_SETTLE: if (tmr_expire) begin
                    state    <= ST_CHECK;
                    done     <= 1'b1;
                    result   <= cnt_q;
                    mismatch <= (cnt_q != expected_q);
                end
                ST_CHECK: begin
                    state       <= ST_IDLE;
                    cmd_ready   <= 1'b1;
                    busy        <= 1'b0;
                    cnt_enable  <= 1'b0;
                    cnt_up_down <= 1'b0;
                    cnt_data    <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_stim_driver.sv
// Bench for counter_stim_driver with a behavioural counter on the pin interface.
module tb_counter_stim_driver;

    localparam int HP  = 4;
    localparam int SET = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_load_val;
    logic [7:0] cmd_steps;
    logic       cmd_up;
    logic       cnt_enable;
    logic       cnt_clk;
    logic       cnt_load;
    logic       cnt_up_down;
    logic [7:0] cnt_data;
    logic [7:0] cnt_q;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       mismatch;

    counter_stim_driver #(.WIDTH(8), .HALF_PERIOD(HP), .SETTLE(SET)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_load_val (cmd_load_val),
        .cmd_steps    (cmd_steps),
        .cmd_up       (cmd_up),
        .cnt_enable   (cnt_enable),
        .cnt_clk      (cnt_clk),
        .cnt_load     (cnt_load),
        .cnt_up_down  (cnt_up_down),
        .cnt_data     (cnt_data),
        .cnt_q        (cnt_q),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .mismatch     (mismatch)
    );

    always #5 clk = ~clk;

    // Behavioural counter: edge-samples clk_in on the system clock; 'stuck' freezes counting
    logic stuck;
    logic prev_clk_in;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 8'h00;
            prev_clk_in <= 1'b0;
        end else begin
            prev_clk_in <= cnt_clk;
            if (cnt_clk && !prev_clk_in && cnt_enable) begin
                if (cnt_load)
                    cnt_q <= cnt_data;
                else if (!stuck)
                    cnt_q <= cnt_up_down ? cnt_q + 8'd1 : cnt_q - 8'd1;
            end
        end
    end

    typedef struct {
        logic [7:0] res;
        logic       mis;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] ld;
        logic [7:0] st;
        logic       up;
        logic       stk;
        logic [7:0] res;
        logic       mis;
        int         lat;
    } vec_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    int   last_acc = 0;
    exp_t mon_e;
    int   mon_a;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: sampled on the falling edge
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            acc_q.push_back(cyc);
            acc_cnt++;
            last_acc = cyc;
        end
        if (!rst && done) begin
            done_cnt++;
            chk("ready_with_done", int'(cmd_ready), 0);
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                chk("result", int'(result), int'(mon_e.res));
                chk("mismatch", int'(mismatch), int'(mon_e.mis));
                chk("latency", cyc - mon_a, mon_e.lat);
            end
        end
    end

    task automatic push_exp(input logic [7:0] r, input logic m, input int l);
        exp_t e;
        e.res = r;
        e.mis = m;
        e.lat = l;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] ld, input logic [7:0] st, input logic up,
                        input logic [7:0] r, input logic m, input int l);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        cmd_load_val = ld;
        cmd_steps    = st;
        cmd_up       = up;
        cmd_valid    = 1'b1;
        push_exp(r, m, l);
        for (int b = 0; b < 200 && !got; b++) begin
            @(negedge clk);
            got = cmd_ready;
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("load_hi_load", int'(cnt_load), 1);
        chk("load_hi_clk", int'(cnt_clk), 1);
        chk("load_hi_data", int'(cnt_data), int'(ld));
        chk("load_hi_en", int'(cnt_enable), 1);
        chk("load_hi_dir", int'(cnt_up_down), int'(up));
        chk("load_hi_busy", int'(busy), 1);
    endtask

    task automatic wait_done(input int target);
        for (int b = 0; b < 400 && done_cnt < target; b++) begin
            @(negedge clk); #1;
        end
        chk("done_seen", int'(done_cnt >= target), 1);
    endtask

    vec_t vecs[8];
    int   first_acc;
    int   a0;
    int   base;
    bit   found;

    initial begin
        vecs[0] = '{8'h10, 8'd3, 1'b1, 1'b0, 8'h13, 1'b0, 37};
        vecs[1] = '{8'hFE, 8'd3, 1'b1, 1'b0, 8'h01, 1'b0, 37};
        vecs[2] = '{8'h02, 8'd0, 1'b0, 1'b0, 8'h02, 1'b0, 13};
        vecs[3] = '{8'h05, 8'd2, 1'b1, 1'b1, 8'h05, 1'b1, 29};
        vecs[4] = '{8'h00, 8'd1, 1'b0, 1'b0, 8'hFF, 1'b0, 21};
        vecs[5] = '{8'hFF, 8'd1, 1'b1, 1'b0, 8'h00, 1'b0, 21};
        vecs[6] = '{8'h80, 8'd5, 1'b0, 1'b0, 8'h7B, 1'b0, 53};
        vecs[7] = '{8'h33, 8'd0, 1'b1, 1'b1, 8'h33, 1'b0, 13};

        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_load_val = 8'h00;
        cmd_steps    = 8'h00;
        cmd_up       = 1'b0;
        stuck        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_clk_in", int'(cnt_clk), 0);
        chk("rst_enable", int'(cnt_enable), 0);
        chk("rst_load", int'(cnt_load), 0);
        chk("rst_data", int'(cnt_data), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            stuck = vecs[i].stk;
            send(vecs[i].ld, vecs[i].st, vecs[i].up, vecs[i].res, vecs[i].mis, vecs[i].lat);
            wait_done(i + 1);
        end
        stuck = 1'b0;

        // Asynchronous reset in the middle of a step-high phase
        base = done_cnt;
        send(8'h40, 8'd4, 1'b1, 8'h44, 1'b0, 45);
        found = 1'b0;
        for (int b = 0; b < 100 && !found; b++) begin
            @(negedge clk);
            found = cnt_clk && !cnt_load && busy;
        end
        chk("reach_step_hi", int'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_clk_in", int'(cnt_clk), 0);
        chk("arst_enable", int'(cnt_enable), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(cmd_ready), 1);
        chk("arst_data", int'(cnt_data), 0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("arst_no_done", done_cnt, base);
        send(8'h7F, 8'd1, 1'b1, 8'h80, 1'b0, 21);
        wait_done(base + 1);

        // Back-to-back: cmd_valid held high, second command presented while busy
        base = done_cnt;
        a0   = acc_cnt;
        @(posedge clk); #1;
        cmd_load_val = 8'h20;
        cmd_steps    = 8'd1;
        cmd_up       = 1'b1;
        cmd_valid    = 1'b1;
        push_exp(8'h21, 1'b0, 21);
        for (int b = 0; b < 100 && acc_cnt < a0 + 1; b++) begin
            @(negedge clk); #1;
        end
        first_acc = last_acc;
        @(posedge clk); #1;
        cmd_load_val = 8'h30;
        cmd_steps    = 8'd2;
        cmd_up       = 1'b0;
        push_exp(8'h2E, 1'b0, 29);
        for (int b = 0; b < 100 && acc_cnt < a0 + 2; b++) begin
            @(negedge clk); #1;
        end
        chk("b2b_accepts", acc_cnt - a0, 2);
        chk("b2b_gap", last_acc - first_acc, 2 * HP * 2 + SET + 2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(base + 2);

        repeat (5) @(negedge clk);
        chk("leftover_expected", exp_q.size(), 0);
        chk("leftover_accepts", acc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
